commit_monitor: RTL and testbench

Synthesizable retire-side monitor for the N-way out-of-order core. It sits beside the processor's commit outputs and counts cycles and retired instructions. It buffers per-instruction commit records in a multi-write trace FIFO drained by a valid/ready consumer. It decides when the run ends: on an error status or a no-commit watchdog timeout, and only after the trace has fully drained.

---
 rtl/commit_monitor.sv | 174 +++++++++++++++++
 tb/tb_commit_monitor.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/commit_monitor.sv
// Retire-side monitor: counts cycles/instructions, queues commit records in a
// multi-write trace FIFO and decides when the run ends (error or watchdog).
package commit_monitor_pkg;
   typedef enum logic [3:0] {
      NO_ERROR     = 4'd0,
      ILLEGAL_INST = 4'd1,
      LOAD_FAULT   = 4'd2,
      STORE_FAULT  = 4'd3,
      ECALL_TRAP   = 4'd4
   } exception_code_e;
endpackage

// Per-lane write slot: lane i lands at wptr+i when the group is accepted.
module commit_monitor_lane #(
   parameter int DEPTH = 16,
   parameter int LANE  = 0,
   parameter int NW    = 2
) (
   input  logic                     push,
   input  logic [NW-1:0]            n,
   input  logic [$clog2(DEPTH)-1:0] wptr,
   output logic                     we,
   output logic [$clog2(DEPTH)-1:0] idx
);
   localparam int PW = $clog2(DEPTH);
   assign we  = push && (int'(n) > LANE);
   assign idx = wptr + PW'(LANE);
endmodule

module commit_monitor
   import commit_monitor_pkg::*;
#(
   parameter int WAYS       = 3,
   parameter int XLEN       = 32,
   parameter int DEPTH      = 16,
   parameter int CNT_W      = 64,
   parameter int WDOG_LIMIT = 50_000_000
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic [WAYS-1:0]            commit_valid,
   input  logic [WAYS-1:0]            commit_wr_en,
   input  logic [WAYS-1:0][4:0]       commit_arn,
   input  logic [WAYS-1:0][XLEN-1:0]  commit_pc,
   input  logic [WAYS-1:0][XLEN-1:0]  commit_data,
   input  exception_code_e            error_status,
   output logic                       trace_valid,
   input  logic                       trace_ready,
   output logic [XLEN-1:0]            trace_pc,
   output logic [XLEN-1:0]            trace_data,
   output logic [4:0]                 trace_arn,
   output logic                       trace_wr_en,
   output logic [CNT_W-1:0]           cycle_count,
   output logic [CNT_W-1:0]           instr_count,
   output logic [CNT_W-1:0]           drop_count,
   output logic                       overflow,
   output logic                       halted,
   output logic [1:0]                 halt_cause,
   output exception_code_e            halt_code
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int NW = $clog2(WAYS + 1);
   localparam int IW = $clog2(WDOG_LIMIT + 1);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] data;
      logic [4:0]      arn;
      logic            wr_en;
   } rec_t;

   typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_e;

   state_e               state, state_nx;
   rec_t                 mem [DEPTH];
   rec_t                 head;
   logic [PW-1:0]        wptr, rptr;
   logic [CW-1:0]        count, free;
   logic [IW-1:0]        idle;
   logic [NW-1:0]        n;
   logic                 run, fits, push, drop, pop, err, wdog;
   logic [WAYS-1:0]      lane_we;
   logic [WAYS-1:0][PW-1:0] lane_idx;

   always_comb begin
      n = '0;
      for (int i = 0; i < WAYS; i++) n = n + NW'(commit_valid[i]);
   end

   // Free space is judged on the pre-pop count, so a full FIFO drops even if it pops this cycle.
   assign run         = (state == RUN);
   assign free        = CW'(DEPTH) - count;
   assign fits        = (free >= CW'(n));
   assign push        = run && (n != '0) && fits;
   assign drop        = run && (n != '0) && !fits;
   assign trace_valid = (count != '0);
   assign pop         = trace_valid && trace_ready;
   assign err         = (error_status != NO_ERROR);
   assign wdog        = (idle == IW'(WDOG_LIMIT - 1)) && (n == '0);

   for (genvar g = 0; g < WAYS; g++) begin : g_lane
      commit_monitor_lane #(.DEPTH(DEPTH), .LANE(g), .NW(NW)) u_lane (
         .push (push),
         .n    (n),
         .wptr (wptr),
         .we   (lane_we[g]),
         .idx  (lane_idx[g])
      );
   end

   always_comb begin
      state_nx = state;
      case (state)
         RUN:     if (err || wdog) state_nx = DRAIN;
         DRAIN:   if (count == '0) state_nx = HALTED;
         HALTED:  state_nx = HALTED;
         default: state_nx = RUN;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state       <= RUN;
         wptr        <= '0;
         rptr        <= '0;
         count       <= '0;
         idle        <= '0;
         cycle_count <= '0;
         instr_count <= '0;
         drop_count  <= '0;
         overflow    <= 1'b0;
         halt_cause  <= 2'd0;
         halt_code   <= NO_ERROR;
      end else begin
         state <= state_nx;
         if (pop)  rptr <= rptr + 1'b1;
         if (push) wptr <= wptr + PW'(n);
         count <= count + (push ? CW'(n) : CW'(0)) - (pop ? CW'(1) : CW'(0));
         if (run) begin
            cycle_count <= cycle_count + 1'b1;
            instr_count <= instr_count + CNT_W'(n);
            idle        <= (n != '0) ? '0 : idle + 1'b1;
            if (drop) begin
               drop_count <= drop_count + CNT_W'(n);
               overflow   <= 1'b1;
            end
            // Error outranks a coincident watchdog expiry.
            if (err) begin
               halt_cause <= 2'd1;
               halt_code  <= error_status;
            end else if (wdog) begin
               halt_cause <= 2'd2;
               halt_code  <= NO_ERROR;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      for (int i = 0; i < WAYS; i++)
         if (lane_we[i])
            mem[lane_idx[i]] <= '{pc: commit_pc[i], data: commit_data[i],
                                  arn: commit_arn[i], wr_en: commit_wr_en[i]};
   end

   // Storage is not reset; gating on trace_valid keeps the head outputs at 0 when empty.
   assign head        = mem[rptr];
   assign trace_pc    = trace_valid ? head.pc    : '0;
   assign trace_data  = trace_valid ? head.data  : '0;
   assign trace_arn   = trace_valid ? head.arn   : '0;
   assign trace_wr_en = trace_valid ? head.wr_en : 1'b0;
   assign halted      = (state == HALTED);
endmodule

// File: tb/tb_commit_monitor.sv
// Bench for commit_monitor: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_commit_monitor;
   import commit_monitor_pkg::*;
   localparam int WAYS = 3, XLEN = 32, DEPTH = 16, CNT_W = 64, WDOG = 8;

   logic                      clock = 1'b0, reset_n;
   logic [WAYS-1:0]           commit_valid, commit_wr_en;
   logic [WAYS-1:0][4:0]      commit_arn;
   logic [WAYS-1:0][XLEN-1:0] commit_pc, commit_data;
   exception_code_e           error_status, halt_code;
   logic                      trace_valid, trace_ready, trace_wr_en, overflow, halted;
   logic [XLEN-1:0]           trace_pc, trace_data;
   logic [4:0]                trace_arn;
   logic [CNT_W-1:0]          cycle_count, instr_count, drop_count;
   logic [1:0]                halt_cause;

   commit_monitor #(.WAYS(WAYS), .XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W), .WDOG_LIMIT(WDOG)) dut (
      .clock(clock), .reset_n(reset_n), .commit_valid(commit_valid), .commit_wr_en(commit_wr_en),
      .commit_arn(commit_arn), .commit_pc(commit_pc), .commit_data(commit_data),
      .error_status(error_status), .trace_valid(trace_valid), .trace_ready(trace_ready),
      .trace_pc(trace_pc), .trace_data(trace_data), .trace_arn(trace_arn), .trace_wr_en(trace_wr_en),
      .cycle_count(cycle_count), .instr_count(instr_count), .drop_count(drop_count),
      .overflow(overflow), .halted(halted), .halt_cause(halt_cause), .halt_code(halt_code));

   always #5 clock = ~clock;

   int errors = 0, checks = 0;
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: FIFO as a queue, run phase as 0=run 1=drain 2=halted.
   typedef struct {logic [31:0] pc, data; logic [4:0] arn; logic wr_en;} rec_t;
   rec_t            q[$];
   rec_t            tmp;
   int              m_state, m_idle_run, m_cause, nn, sz;
   longint unsigned m_cyc, m_instr, m_drop;
   bit              m_ovf, model_ok = 0;
   exception_code_e m_code;
   int              tick = 0, last_pop_tick = -1, halt_tick = -1;
   logic [31:0]     popped[$];

   always @(posedge clock) begin
      tick++;
      if (!reset_n) begin
         q.delete(); m_state = 0; m_idle_run = 0; m_cause = 0; m_code = NO_ERROR;
         m_cyc = 0; m_instr = 0; m_drop = 0; m_ovf = 0; model_ok = 1;
      end else if (model_ok) begin
         sz = q.size();
         nn = 0;
         for (int i = 0; i < WAYS; i++) nn += int'(commit_valid[i]);
         if (sz != 0 && trace_ready) tmp = q.pop_front();
         if (m_state == 0) begin
            m_cyc++;
            m_instr += longint'(nn);
            if (nn > 0) begin
               if (DEPTH - sz >= nn) begin
                  for (int i = 0; i < nn; i++) begin
                     tmp.pc = commit_pc[i]; tmp.data = commit_data[i];
                     tmp.arn = commit_arn[i]; tmp.wr_en = commit_wr_en[i];
                     q.push_back(tmp);
                  end
               end else begin
                  m_drop += longint'(nn); m_ovf = 1;
               end
            end
            m_idle_run = (nn == 0) ? m_idle_run + 1 : 0;
            if (error_status != NO_ERROR) begin
               m_state = 1; m_cause = 1; m_code = error_status;
            end else if (m_idle_run == WDOG) begin
               m_state = 1; m_cause = 2; m_code = NO_ERROR;
            end
         end else if (m_state == 1 && sz == 0) m_state = 2;
      end
   end

   always @(negedge clock) begin
      if (model_ok) begin
         chk("trace_valid", trace_valid, q.size() != 0);
         if (q.size() != 0) begin
            chk("trace_pc", trace_pc, q[0].pc);
            chk("trace_data", trace_data, q[0].data);
            chk("trace_arn", trace_arn, q[0].arn);
            chk("trace_wr_en", trace_wr_en, q[0].wr_en);
         end else begin
            chk("trace_idle_zero", {trace_pc, trace_data, trace_arn, trace_wr_en}, 64'd0);
         end
         chk("cycle_count", cycle_count, m_cyc);
         chk("instr_count", instr_count, m_instr);
         chk("drop_count", drop_count, m_drop);
         chk("overflow", overflow, m_ovf);
         chk("halted", halted, m_state == 2);
         chk("halt_cause", halt_cause, m_cause);
         chk("halt_code", halt_code, m_code);
         if (reset_n && trace_valid && trace_ready) begin
            popped.push_back(trace_pc);
            last_pop_tick = tick + 1;
         end
         if (halted && halt_tick < 0) halt_tick = tick;
      end
   end

   task automatic cyc(input int nv, input logic [31:0] pc0, input logic rdy,
                      input exception_code_e err = NO_ERROR);
      for (int i = 0; i < WAYS; i++) begin
         commit_valid[i] = (i < nv);
         commit_pc[i]    = pc0 + 32'(4 * i);
         commit_arn[i]   = 5'((pc0 >> 2) + 32'(i));
         commit_data[i]  = 32'hD000_0000 | (pc0 + 32'(4 * i));
         commit_wr_en[i] = (((pc0 >> 2) + 32'(i)) % 3) != 0;
      end
      trace_ready  = rdy;
      error_status = err;
      @(posedge clock); #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      cyc(0, 0, 0);
      reset_n = 1'b1;
      popped.delete();
      halt_tick = -1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation ran past its time budget");
      $fatal(1);
   end

   initial begin
      bit ok;
      reset_n = 1'b0;
      do_reset();
      chk("rst_instr", instr_count, 0);
      chk("rst_valid", trace_valid, 0);

      // Full 3-lane groups, ready high: FIFO fills 2/cycle, groups 8 and 9 dropped.
      for (int k = 0; k < 10; k++) cyc(3, 32'(12 * k), 1);
      chk("t1_instr", instr_count, 30);
      chk("t1_cycle", cycle_count, 10);
      chk("t1_drop", drop_count, 6);
      for (int k = 0; k < 18; k++) cyc(0, 0, 1);
      chk("t1_pops", popped.size(), 24);
      ok = (popped.size() > 0) && (popped[0] == 0);
      for (int k = 1; k < popped.size(); k++) if (popped[k] <= popped[k-1]) ok = 0;
      chk("t1_order", ok, 1);
      chk("t1_wdog_halt", {halted, halt_cause}, {1'b1, 2'd2});

      // Ready low: 15 stored, 6th group dropped, then exactly 15 drained.
      do_reset();
      for (int k = 0; k < 6; k++) cyc(3, 32'(12 * k), 0);
      chk("t2_drop", drop_count, 3);
      chk("t2_ovf", overflow, 1);
      chk("t2_instr", instr_count, 18);
      for (int k = 0; k < 20; k++) cyc(0, 0, 1);
      chk("t2_pops", popped.size(), 15);

      // Partial groups 1,2,0,3; idle counter restarts after the nonzero group.
      do_reset();
      cyc(1, 32'h100, 1); cyc(2, 32'h200, 1); cyc(0, 0, 1); cyc(3, 32'h300, 1);
      chk("t3_instr", instr_count, 6);
      for (int k = 0; k < 7; k++) cyc(0, 0, 1);
      chk("t3_cycle", cycle_count, 11);
      chk("t3_not_halted", halted, 0);
      chk("t3_pops", popped.size(), 6);
      if (popped.size() == 6) begin
         chk("t3_pop1", popped[1], 32'h200);
         chk("t3_pop3", popped[3], 32'h300);
      end

      // Error with 2 commits and 4 queued entries.
      do_reset();
      cyc(2, 32'h400, 0); cyc(2, 32'h408, 0); cyc(2, 32'h410, 1, ILLEGAL_INST);
      for (int k = 0; k < 8; k++) cyc(3, 32'h500, 1);
      chk("t4_instr", instr_count, 6);
      chk("t4_cycle", cycle_count, 3);
      chk("t4_halted", halted, 1);
      chk("t4_cause", halt_cause, 1);
      chk("t4_code", halt_code, ILLEGAL_INST);
      chk("t4_pops", popped.size(), 6);
      chk("t4_halt_lat", halt_tick, last_pop_tick + 1);

      // Watchdog alone, then watchdog coinciding with an error.
      do_reset();
      for (int k = 0; k < 8; k++) cyc(0, 0, 1);
      chk("t5_drain_not_halted", halted, 0);
      chk("t5_cycle", cycle_count, 8);
      cyc(0, 0, 1);
      chk("t5_halted", halted, 1);
      chk("t5_cause", halt_cause, 2);
      chk("t5_code", halt_code, NO_ERROR);
      do_reset();
      for (int k = 0; k < 7; k++) cyc(0, 0, 1);
      cyc(0, 0, 1, LOAD_FAULT);
      cyc(0, 0, 1);
      chk("t5b_cause", halt_cause, 1);
      chk("t5b_code", halt_code, LOAD_FAULT);

      // Reset mid-drain discards the queued records.
      do_reset();
      cyc(3, 32'h600, 0); cyc(3, 32'h60C, 0); cyc(0, 0, 0, STORE_FAULT); cyc(0, 0, 0);
      chk("t6_draining", {trace_valid, halted}, {1'b1, 1'b0});
      reset_n = 1'b0;
      cyc(0, 0, 0);
      reset_n = 1'b1;
      chk("t6_valid", trace_valid, 0);
      chk("t6_halted", halted, 0);
      chk("t6_counts", cycle_count | instr_count | drop_count, 0);
      chk("t6_cause", halt_cause, 0);
      cyc(1, 32'h700, 1);
      chk("t6_new_valid", trace_valid, 1);
      chk("t6_new_pc", trace_pc, 32'h700);
      chk("t6_new_data", trace_data, 32'hD000_0700);
      cyc(0, 0, 1); cyc(0, 0, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
